com_link_responder: RTL and testbench
=====================================

Name: com_link_responder

Overview:
- FPGA-side responder of the host readout link: LVDS SCK/MOSI in, MISO/RDY out, SPI mode 0, MSB first, no chip select.
- Raises RDY when the acquisition block buffer holds a full BLOCKSIZE-byte block.
- Decodes an 8-bit host command; on READ, streams the block out of the buffer onto MISO, then releases the buffer.
- Sits in Top between the LVDS I/O buffers and the sample block buffer.

Parameters:
- BLOCKSIZE, 1024: bytes per block transfer.
- ADDR_W, 10: buffer address width, equal to clog2(BLOCKSIZE).
- IDLE_TIMEOUT, 64: clk cycles of SCK inactivity that resynchronise bit framing.

Ports:
- clk  in  1  system clock, at least 4x SCK frequency (100 MHz nominal, SCK up to 25 MHz).
- rst  in  1  synchronous, active-high reset.
- sck_in  in  1  host SCK from INBUF_LVDS; asynchronous.
- mosi_in  in  1  host MOSI from INBUF_LVDS; asynchronous.
- miso_out  out  1  data to host, to OUTBUF_LVDS.
- rdy_out  out  1  block-ready flag to host, to OUTBUF_LVDS.
- blk_ready  in  1  level: buffer holds a complete block.
- blk_release  out  1  1-cycle pulse: block consumed, buffer may refill.
- mem_rden  out  1  buffer read enable.
- mem_addr  out  ADDR_W  buffer byte address.
- mem_data  in  8  buffer read data, valid 1 clk after mem_rden.
- arm  out  1  1-cycle pulse on START command.
- cmd_err  out  1  1-cycle pulse on unknown command, or READ with no block ready.

Behaviour:
- Clocking and reset: one clock, clk; synchronous active-high reset, rst.
- Input sync: sck_in and mosi_in each pass through 2-FF synchronisers; rise/fall edges are detected from the synchronised SCK.
- Sampling: MOSI is sampled on detected SCK rise.
- Shifting: MISO shifts on detected SCK fall, MSB first.
- Reset values: miso_out=0, rdy_out=0, blk_release=0, mem_rden=0, mem_addr=0, arm=0, cmd_err=0; state=IDLE; bit and byte counters=0.
- Command codes: START=8'hFB asserts arm; READ=8'hF8 starts a block stream; all other values assert cmd_err.
- IDLE state:
  - rdy_out = blk_ready.
  - On the first SCK rise, go to CMD; rdy_out drops in the same cycle.
- CMD state:
  - Shift in 8 bits; miso_out=0 throughout.
  - After the 8th rise, go to DECODE.
- DECODE state (1 cycle):
  - START: pulse arm, return to IDLE.
  - READ with blk_ready=1: set mem_addr=0, assert mem_rden, go to LOAD.
  - READ with blk_ready=0, or any unknown code: pulse cmd_err, return to IDLE.
- LOAD state: capture mem_data into the tx shift register and drive its MSB on miso_out. This happens within 4 clk of the 8th command rise, before the host's first data rise (at least 120 ns later).
- STREAM state:
  - Each SCK fall shifts out the next bit.
  - On the fall after the 7th bit of a byte, prefetch the next byte: mem_addr+1, mem_rden.
  - On the 8th fall, load the prefetched byte and drive its MSB.
  - After the 8th rise of byte BLOCKSIZE-1, go to DONE.
- DONE state (1 cycle): pulse blk_release, miso_out=0, return to IDLE.
- Timing: inter-byte gaps of any length are legal. Back-to-back bytes with no gap are also legal, since prefetch completes within one SCK half-period.
- Framing resync: in CMD or STREAM, if no SCK edge is seen for IDLE_TIMEOUT clk, abort to IDLE, clear the counters and set miso_out=0. No blk_release is issued; the block is retained and rdy_out re-asserts if blk_ready=1.
- blk_ready falling mid-stream is ignored; the buffer owner must hold data until blk_release.
- SCK rise and timeout never occur in the same cycle, because the timeout counter clears on every edge.
- mem_addr wraps only through the reset to 0 in DECODE; it never exceeds BLOCKSIZE-1.
- rst mid-transfer: immediate return to IDLE with reset values; no blk_release.

Decomposition:
- Package com_link_pkg:
  - Command localparams CMD_START=8'hFB, CMD_READ=8'hF8.
  - State enum typedef com_state_t {IDLE, CMD, DECODE, LOAD, STREAM, DONE}.
- Sub-module com_sck_sync: 2-FF synchronisers for SCK and MOSI plus rise/fall edge pulses. Reused by any other LVDS serial slave.

Test Plan:
- Reset, blk_ready=1 -> rdy_out=1 within 2 clk of rst release; all other outputs 0.
- Host sends 8'hFB -> arm pulses once for 1 clk; cmd_err=0; rdy_out re-asserts after DECODE.
- blk_ready=1, buffer filled with pattern addr[7:0]; host sends 8'hF8 then 1024x8 clocks with 100 ns byte gaps -> bytes 0x00..0xFF repeating, 1024 bytes received; blk_release pulses once after the last rise; rdy_out=0 during the stream.
- Host sends 8'hF8 with blk_ready=0 -> cmd_err pulse, no mem_rden. Host sends 8'h55 -> cmd_err pulse.
- Host stops after 3 bits of byte 10 and waits 2x IDLE_TIMEOUT -> returns to IDLE, no blk_release, rdy_out=1. A following READ restarts from address 0.
- Back-to-back bytes with no gap at 25 MHz SCK, and rst asserted mid-byte 500 -> data correct up to the reset; afterwards all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/com_link_pkg.sv
// Shared command codes and FSM state type for the host readout link.
// Imported by the responder and its bench.
`timescale 1ns/1ps
package com_link_pkg;

  localparam logic [7:0] CMD_START = 8'hFB;
  localparam logic [7:0] CMD_READ  = 8'hF8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DECODE,
    LOAD,
    STREAM,
    DONE
  } com_state_t;

endpackage

// File: rtl/com_link_responder_if.sv
// Block-buffer side of the readout link: ready/release handshake plus
// read bus. master = responder, slave = buffer owner.
`timescale 1ns/1ps
interface com_link_responder_if #(
  parameter int ADDR_W = 10
);

  logic              blk_ready;
  logic              blk_release;
  logic              mem_rden;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (
    input  blk_ready,
    input  mem_data,
    output blk_release,
    output mem_rden,
    output mem_addr
  );

  modport slave (
    output blk_ready,
    output mem_data,
    input  blk_release,
    input  mem_rden,
    input  mem_addr
  );

endinterface

// File: rtl/com_sck_sync.sv
// 2-FF synchronisers for an async SCK/MOSI pair plus SCK rise/fall pulses.
// Ports: clk, rst, sck_i, mosi_i -> sck_rise_o, sck_fall_o, mosi_o.
`timescale 1ns/1ps
module com_sck_sync (
  input  logic clk,
  input  logic rst,
  input  logic sck_i,
  input  logic mosi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic mosi_o
);

  // sck_q[2] is the previous synchronised value used for edge detect.
  logic [2:0] sck_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck_i};
      mosi_q <= {mosi_q[0], mosi_i};
    end
  end

  // MOSI has the same sync depth as SCK, so it lines up with the rise pulse.
  assign sck_rise_o = sck_q[1] & ~sck_q[2];
  assign sck_fall_o = ~sck_q[1] & sck_q[2];
  assign mosi_o     = mosi_q[1];

endmodule

// File: rtl/com_link_responder.sv
// Host readout link responder (SPI mode 0 slave, MSB first, no CS).
// Ports: clk, rst, sck_in, mosi_in, miso_out, rdy_out, arm, cmd_err, bus.
`timescale 1ns/1ps
module com_link_responder
  import com_link_pkg::*;
#(
  parameter int BLOCKSIZE    = 1024,
  parameter int ADDR_W       = 10,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic sck_in,
  input  logic mosi_in,
  output logic miso_out,
  output logic rdy_out,
  output logic arm,
  output logic cmd_err,
  com_link_responder_if.master bus
);

  localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(BLOCKSIZE - 1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
  localparam logic [TO_W-1:0]   TO_MAX = TO_W'(IDLE_TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ONE = TO_W'(1);

  logic rise;
  logic fall;
  logic mosi_s;

  com_state_t        state_q, state_d;
  logic [3:0]        bit_q, bit_d;
  logic [ADDR_W-1:0] byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        nxt_q, nxt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              rdy_q, rdy_d;
  logic              rel_q, rel_d;
  logic              rden_q, rden_d;
  logic              pend_q;
  logic              arm_q, arm_d;
  logic              err_q, err_d;

  com_sck_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .sck_i      (sck_in),
    .mosi_i     (mosi_in),
    .sck_rise_o (rise),
    .sck_fall_o (fall),
    .mosi_o     (mosi_s)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    // Read data arrives one clk after rden; latch it as the next byte.
    nxt_d   = pend_q ? bus.mem_data : nxt_q;
    to_d    = '0;
    rel_d   = 1'b0;
    rden_d  = 1'b0;
    arm_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        bit_d  = '0;
        byte_d = '0;
        if (rise) begin
          rx_d    = {rx_q[6:0], mosi_s};
          bit_d   = 4'd1;
          state_d = CMD;
        end
      end

      CMD: begin
        to_d = to_q + TO_ONE;
        if (rise) begin
          to_d = '0;
          rx_d = {rx_q[6:0], mosi_s};
          if (bit_q == 4'd7) begin
            bit_d   = '0;
            state_d = DECODE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else if (fall) begin
          to_d = '0;
        end else if (to_q == TO_MAX) begin
          to_d    = '0;
          bit_d   = '0;
          byte_d  = '0;
          tx_d    = '0;
          state_d = IDLE;
        end
      end

      DECODE: begin
        unique case (1'b1)
          (rx_q == CMD_START): begin
            arm_d   = 1'b1;
            state_d = IDLE;
          end
          (rx_q == CMD_READ) && bus.blk_ready: begin
            addr_d  = '0;
            rden_d  = 1'b1;
            byte_d  = '0;
            bit_d   = '0;
            state_d = LOAD;
          end
          default: begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        endcase
      end

      LOAD: begin
        if (pend_q) begin
          tx_d    = bus.mem_data;
          state_d = STREAM;
        end
      end

      STREAM: begin
        to_d = to_q + TO_ONE;
        if (rise) begin
          to_d = '0;
          if ((bit_q == 4'd7) && (byte_q == LAST)) begin
            bit_d   = '0;
            state_d = DONE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else if (fall) begin
          to_d = '0;
          // bit_q==0 is the stray fall right after a rise-less load.
          if (bit_q == 4'd8) begin
            tx_d   = nxt_q;
            bit_d  = '0;
            byte_d = byte_q + A_ONE;
          end else if (bit_q != 4'd0) begin
            tx_d = {tx_q[6:0], 1'b0};
            if ((bit_q == 4'd7) && (byte_q != LAST)) begin
              addr_d = addr_q + A_ONE;
              rden_d = 1'b1;
            end
          end
        end else if (to_q == TO_MAX) begin
          to_d    = '0;
          bit_d   = '0;
          byte_d  = '0;
          tx_d    = '0;
          state_d = IDLE;
        end
      end

      DONE: begin
        rel_d   = 1'b1;
        tx_d    = '0;
        bit_d   = '0;
        byte_d  = '0;
        state_d = IDLE;
      end

      default: begin
        tx_d    = '0;
        state_d = IDLE;
      end
    endcase

    rdy_d = (state_d == IDLE) && bus.blk_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      byte_q  <= '0;
      addr_q  <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      nxt_q   <= '0;
      to_q    <= '0;
      rdy_q   <= 1'b0;
      rel_q   <= 1'b0;
      rden_q  <= 1'b0;
      pend_q  <= 1'b0;
      arm_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      nxt_q   <= nxt_d;
      to_q    <= to_d;
      rdy_q   <= rdy_d;
      rel_q   <= rel_d;
      rden_q  <= rden_d;
      pend_q  <= rden_q;
      arm_q   <= arm_d;
      err_q   <= err_d;
    end
  end

  // tx_q is cleared outside LOAD/STREAM, so its MSB is the MISO line.
  assign miso_out        = tx_q[7];
  assign rdy_out         = rdy_q;
  assign arm             = arm_q;
  assign cmd_err         = err_q;
  assign bus.blk_release = rel_q;
  assign bus.mem_rden    = rden_q;
  assign bus.mem_addr    = addr_q;

endmodule

// File: tb/tb_com_link_responder.sv
// Directed bench for com_link_responder: host SPI model plus a buffer
// that returns addr[7:0] one clk after mem_rden.
`timescale 1ns/1ps
module tb_com_link_responder;
  import com_link_pkg::*;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic sck  = 1'b0;
  logic mosi = 1'b0;
  logic miso;
  logic rdy;
  logic arm;
  logic err;

  int n_cmp = 0;
  int n_bad = 0;
  int arm_n = 0;
  int err_n = 0;
  int rel_n = 0;
  int rden_n = 0;

  logic [7:0] rx;

  com_link_responder_if #(.ADDR_W(10)) bus ();

  always #5 clk = ~clk;

  com_link_responder #(
    .BLOCKSIZE    (1024),
    .ADDR_W       (10),
    .IDLE_TIMEOUT (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sck_in   (sck),
    .mosi_in  (mosi),
    .miso_out (miso),
    .rdy_out  (rdy),
    .arm      (arm),
    .cmd_err  (err),
    .bus      (bus)
  );

  always @(posedge clk) begin
    if (bus.mem_rden) bus.mem_data <= bus.mem_addr[7:0];
  end

  always @(posedge clk) begin
    if (arm)             arm_n  <= arm_n + 1;
    if (err)             err_n  <= err_n + 1;
    if (bus.blk_release) rel_n  <= rel_n + 1;
    if (bus.mem_rden)    rden_n <= rden_n + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 25 MHz host: MOSI set while SCK low, MISO sampled at end of high.
  task automatic sbyte(input logic [7:0] tx, input int nbits,
                       output logic [7:0] r);
    r = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      #20 sck = 1'b1;
      #20 r[i] = miso;
      sck = 1'b0;
    end
  endtask

  initial begin
    bus.blk_ready = 1'b1;
    rst = 1'b1;
    clks(4);
    chk("rst_rdy", 32'(rdy), 0);
    rst = 1'b0;
    clks(2);
    chk("rel_rdy", 32'(rdy), 1);
    chk("rel_miso", 32'(miso), 0);
    chk("rel_arm", 32'(arm), 0);
    chk("rel_err", 32'(err), 0);
    chk("rel_blkrel", 32'(bus.blk_release), 0);
    chk("rel_rden", 32'(bus.mem_rden), 0);
    chk("rel_addr", 32'(bus.mem_addr), 0);

    // START
    sbyte(CMD_START, 8, rx);
    clks(10);
    chk("start_arm", arm_n, 1);
    chk("start_err", err_n, 0);
    chk("start_rdy", 32'(rdy), 1);

    // READ without a block, then an unknown code
    bus.blk_ready = 1'b0;
    clks(2);
    sbyte(CMD_READ, 8, rx);
    clks(10);
    chk("rd_nb_err", err_n, 1);
    chk("rd_nb_rden", rden_n, 0);
    chk("rd_nb_rdy", 32'(rdy), 0);
    sbyte(8'h55, 8, rx);
    clks(10);
    chk("bad_err", err_n, 2);
    chk("bad_arm", arm_n, 1);

    // full block, 100 ns byte gaps
    bus.blk_ready = 1'b1;
    clks(4);
    chk("blk_rdy", 32'(rdy), 1);
    sbyte(CMD_READ, 8, rx);
    #200;
    for (int b = 0; b < 1024; b++) begin
      sbyte(8'h00, 8, rx);
      chk("blk_byte", 32'(rx), b & 255);
      if (b == 512) chk("blk_rdy_low", 32'(rdy), 0);
      #100;
    end
    clks(10);
    chk("blk_rel", rel_n, 1);
    chk("blk_rdy_back", 32'(rdy), 1);
    chk("blk_miso", 32'(miso), 0);

    // stall after 3 bits of byte 10
    sbyte(CMD_READ, 8, rx);
    #200;
    for (int b = 0; b < 10; b++) begin
      sbyte(8'h00, 8, rx);
      chk("to_byte", 32'(rx), b);
      #100;
    end
    sbyte(8'h00, 3, rx);
    clks(128);
    chk("to_rel", rel_n, 1);
    chk("to_rdy", 32'(rdy), 1);
    chk("to_miso", 32'(miso), 0);
    chk("to_state", 32'(dut.state_q), 32'(IDLE));
    sbyte(CMD_READ, 8, rx);
    #200;
    sbyte(8'h00, 8, rx);
    chk("restart_b0", 32'(rx), 0);
    sbyte(8'h00, 8, rx);
    chk("restart_b1", 32'(rx), 1);
    clks(128);
    chk("restart_rel", rel_n, 1);

    // back-to-back bytes, reset inside byte 500
    sbyte(CMD_READ, 8, rx);
    #200;
    for (int b = 0; b < 500; b++) begin
      sbyte(8'h00, 8, rx);
      chk("b2b_byte", 32'(rx), b & 255);
    end
    sbyte(8'h00, 4, rx);
    chk("b500_hi", 32'(rx[7:4]), 4'hF);
    rst = 1'b1;
    clks(2);
    chk("mrst_miso", 32'(miso), 0);
    chk("mrst_rdy", 32'(rdy), 0);
    chk("mrst_blkrel", 32'(bus.blk_release), 0);
    chk("mrst_rden", 32'(bus.mem_rden), 0);
    chk("mrst_addr", 32'(bus.mem_addr), 0);
    chk("mrst_arm", 32'(arm), 0);
    chk("mrst_err", 32'(err), 0);
    chk("mrst_state", 32'(dut.state_q), 32'(IDLE));
    chk("mrst_relcnt", rel_n, 1);
    rst = 1'b0;
    clks(2);
    chk("mrst_rdy_back", 32'(rdy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
